// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the memory-stage data-access interface. A word-organised
//   synchronous RAM answers one load/store at a time after a fixed number of
//   wait states. A stall is raised to the hazard logic while an access is
//   outstanding. A separate registered debug read port feeds the test-data
//   output.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   req_valid   access presented by the memory stage
//   req_write   1 = store, 0 = load (sampled at accept)
//   req_addr    byte address (sampled at accept)
//   req_wdata   store data (sampled at accept)
//   stall_m     access outstanding, hold the pipeline
//   resp_valid  one-cycle completion pulse
//   resp_rdata  load data (held until the next load response)
//   resp_err    misaligned access flag, valid with resp_valid
//   test_addr   debug word index
//   test_rdata  debug read data, one cycle latency
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall_m,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  input  logic [DEPTH_LOG2-1:0] test_addr,
  output logic [31:0]           test_rdata
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    stIdle,
    stWait,
    stResp
  } state_t;

  state_t                state;
  logic [3:0]            waitCnt;
  logic                  latWrite;
  logic [DEPTH_LOG2+1:0] latAddr;
  logic [31:0]           latData;

  logic                  respValidQ;
  logic [31:0]           respRdataQ;
  logic                  respErrQ;
  logic [31:0]           testRdataQ;

  logic [31:0]           mem [Words];

  // Address bits above the RAM size are dropped so addresses wrap.
  logic                  unusedAddrHi;
  assign unusedAddrHi = ^req_addr[31:DEPTH_LOG2+2];

  // Access operands seen on the edge that enters RESP. With no wait states
  // that edge is the accept edge itself, so the live request is used.
  logic                  accWrite;
  logic [DEPTH_LOG2+1:0] accAddr;
  logic [31:0]           accData;
  logic [DEPTH_LOG2-1:0] accIdx;
  logic                  accMisaligned;
  logic                  enterResp;

  always_comb begin
    accWrite  = latWrite;
    accAddr   = latAddr;
    accData   = latData;
    enterResp = 1'b0;
    if (state == stIdle) begin
      accWrite  = req_write;
      accAddr   = req_addr[DEPTH_LOG2+1:0];
      accData   = req_wdata;
      enterResp = req_valid && (WAIT_CYCLES == 0);
    end else if (state == stWait) begin
      enterResp = (waitCnt == 4'd1);
    end
    accIdx        = accAddr[DEPTH_LOG2+1:2];
    accMisaligned = |accAddr[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= stIdle;
      waitCnt    <= '0;
      latWrite   <= 1'b0;
      latAddr    <= '0;
      latData    <= '0;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
      respErrQ   <= 1'b0;
    end else begin
      respValidQ <= enterResp;
      if (enterResp) begin
        respErrQ <= accMisaligned;
        // Only loads update the read data; store responses leave it held.
        if (!accWrite) begin
          respRdataQ <= accMisaligned ? '0 : mem[accIdx];
        end
      end
      case (state)
        stIdle: begin
          if (req_valid) begin
            latWrite <= req_write;
            latAddr  <= req_addr[DEPTH_LOG2+1:0];
            latData  <= req_wdata;
            waitCnt  <= 4'(WAIT_CYCLES);
            state    <= (WAIT_CYCLES == 0) ? stResp : stWait;
          end
        end
        stWait: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) begin
            state <= stResp;
          end
        end
        stResp:  state <= stIdle;
        default: state <= stIdle;
      endcase
    end
  end

  // RAM write port: contents are not reset, and a request dropped by reset
  // never commits.
  always_ff @(posedge clk) begin
    if (rst && enterResp && accWrite && !accMisaligned) begin
      mem[accIdx] <= accData;
    end
  end

  // Debug read port: a same-edge store is not forwarded, old data is returned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      testRdataQ <= '0;
    end else begin
      testRdataQ <= mem[test_addr];
    end
  end

  assign stall_m    = rst & ((state != stIdle) | req_valid) & ~respValidQ;
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign resp_err   = respErrQ;
  assign test_rdata = testRdataQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Two responders side by side: index 0 with no wait states, index 1 with two.
//   Expected responses (cycle, error flag, load data) are queued when a request
//   is driven and compared by a monitor when resp_valid is seen.
module tb_data_mem_responder;

  localparam int unsigned DL2 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           reqValid  [2];
  logic           reqWrite  [2];
  logic [31:0]    reqAddr   [2];
  logic [31:0]    reqWdata  [2];
  logic           stallM    [2];
  logic           respValid [2];
  logic [31:0]    respRdata [2];
  logic           respErr   [2];
  logic [DL2-1:0] testAddr  [2];
  logic [31:0]    testRdata [2];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .stall_m(stallM[0]), .resp_valid(respValid[0]),
    .resp_rdata(respRdata[0]), .resp_err(respErr[0]),
    .test_addr(testAddr[0]), .test_rdata(testRdata[0])
  );

  data_mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .stall_m(stallM[1]), .resp_valid(respValid[1]),
    .resp_rdata(respRdata[1]), .resp_err(respErr[1]),
    .test_addr(testAddr[1]), .test_rdata(testRdata[1])
  );

  typedef struct {
    int unsigned cyc;
    logic        isLoad;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned lat(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic push(input int d, input int unsigned c, input logic isLoad,
                      input logic [31:0] r, input logic e);
    exp_t x;
    x.cyc = c; x.isLoad = isLoad; x.rdata = r; x.err = e;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic checkResp(input int d, input exp_t e);
    chk($sformatf("d%0d resp cycle", d), cyc, e.cyc);
    chk($sformatf("d%0d resp_err", d), 32'(respErr[d]), 32'(e.err));
    if (e.isLoad) chk($sformatf("d%0d resp_rdata", d), respRdata[d], e.rdata);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (respValid[0]) begin
      if (q0.size() == 0) chk("d0 unexpected resp_valid", 32'(respValid[0]), 32'd0);
      else begin e = q0.pop_front(); checkResp(0, e); end
    end
    if (respValid[1]) begin
      if (q1.size() == 0) chk("d1 unexpected resp_valid", 32'(respValid[1]), 32'd0);
      else begin e = q1.pop_front(); checkResp(1, e); end
    end
  end

  task automatic drive(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    reqValid[d] = 1'b1; reqWrite[d] = w; reqAddr[d] = a; reqWdata[d] = wd;
  endtask

  // Drive one request for one cycle; response expected lat(d) cycles after
  // the negedge following the accept edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] expR, input logic expE);
    @(negedge clk);
    drive(d, w, a, wd);
    push(d, cyc + 1 + lat(d), !w, expR, expE);
    @(negedge clk);
    reqValid[d] = 1'b0;
  endtask

  task automatic waitResp(input int d);
    int n = 0;
    while (!respValid[d] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("d%0d response within bound", d), 32'(respValid[d]), 32'd1);
  endtask

  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] expR, input logic expE);
    issue(d, w, a, wd, expR, expE);
    waitResp(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      reqValid[i] = 1'b0; reqWrite[i] = 1'b0; reqAddr[i] = '0; reqWdata[i] = '0;
      testAddr[i] = DL2'(5);
    end

    // Reset state, with a request present to show stall_m is forced low.
    reqValid[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset stall_m", 32'(stallM[1]), 32'd0);
    chk("reset resp_valid", 32'(respValid[1]), 32'd0);
    chk("reset resp_rdata", respRdata[1], 32'd0);
    chk("reset resp_err", 32'(respErr[1]), 32'd0);
    chk("reset test_rdata", testRdata[1], 32'd0);
    reqValid[1] = 1'b0;
    rst = 1'b1;

    // Two wait states: store with stall profile, then load back.
    @(negedge clk);
    drive(1, 1'b1, 32'h10, 32'hDEADBEEF);
    push(1, cyc + 3, 1'b0, 32'h0, 1'b0);
    #1 chk("stall in accept cycle", 32'(stallM[1]), 32'd1);
    @(negedge clk);
    reqValid[1] = 1'b0;
    chk("stall in wait 1", 32'(stallM[1]), 32'd1);
    @(negedge clk);
    chk("stall in wait 2", 32'(stallM[1]), 32'd1);
    @(negedge clk);
    chk("store resp_valid", 32'(respValid[1]), 32'd1);
    chk("stall in resp", 32'(stallM[1]), 32'd0);
    access(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("resp_valid single pulse", 32'(respValid[1]), 32'd0);
    chk("resp_rdata held", respRdata[1], 32'hDEADBEEF);

    // Misaligned store is suppressed; misaligned load returns 0 with error.
    access(1, 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1);
    access(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    access(1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);

    // Address wrap modulo the RAM size.
    access(1, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h0, 1'b0);
    access(1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Reset during WAIT drops the pending store and produces no response.
    access(1, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 32'h20, 32'h55);
    @(negedge clk);
    reqValid[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-wait reset resp_valid", 32'(respValid[1]), 32'd0);
    chk("mid-wait reset resp_rdata", respRdata[1], 32'd0);
    chk("mid-wait reset resp_err", 32'(respErr[1]), 32'd0);
    chk("mid-wait reset stall_m", 32'(stallM[1]), 32'd0);
    chk("mid-wait reset test_rdata", testRdata[1], 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    access(1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Debug port read and same-edge store returning old data.
    access(1, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0);
    @(negedge clk);
    chk("debug read word 5", testRdata[1], 32'hCAFEF00D);
    issue(1, 1'b1, 32'h14, 32'h0BADF00D, 32'h0, 1'b0);
    waitResp(1);
    chk("debug same-edge old data", testRdata[1], 32'hCAFEF00D);
    @(negedge clk);
    chk("debug after store", testRdata[1], 32'h0BADF00D);

    // No wait states: populate, then two back-to-back loads.
    access(0, 1'b1, 32'h8, 32'h13572468, 32'h0, 1'b0);
    access(0, 1'b1, 32'hC, 32'h24681357, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'h8, 32'h0);
    push(0, cyc + 1, 1'b1, 32'h13572468, 1'b0);
    @(negedge clk);
    chk("b2b first resp_valid", 32'(respValid[0]), 32'd1);
    chk("b2b stall in resp", 32'(stallM[0]), 32'd0);
    drive(0, 1'b0, 32'hC, 32'h0);
    push(0, cyc + 2, 1'b1, 32'h24681357, 1'b0);
    @(negedge clk);
    chk("b2b held request stall", 32'(stallM[0]), 32'd1);
    chk("b2b no resp in idle", 32'(respValid[0]), 32'd0);
    @(negedge clk);
    chk("b2b second resp_valid", 32'(respValid[0]), 32'd1);
    reqValid[0] = 1'b0;

    repeat (3) @(negedge clk);
    chk("d0 outstanding expectations", 32'(q0.size()), 32'd0);
    chk("d1 outstanding expectations", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
